// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-port round-robin request arbiter sharing one ALU_TOP
//
// Purpose:
//   Accepts operand/opcode requests from two requesters over valid/ready,
//   grants them round-robin, drives the shared ALU for ALU_LAT+1 cycles,
//   captures the result of the unit addressed by fun[3:2] and returns it to
//   the originating requester over a valid/ready response channel. One
//   operation in flight at a time.
//
// Ports:
//   CLK, RST                      clock (rising edge), async active-low reset
//   reqN_valid/ready              request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_fun      operands and 4-bit ALU opcode
//   respN_valid/ready             response handshake, N = 0,1
//   resp_data/flag/carry          selected result, shared by both channels
//   alu_a, alu_b, alu_fun         drive to ALU_TOP
//   alu_*_out, alu_*_flag,
//   alu_carry_out                 registered results/flags from ALU_TOP
//   busy                          high whenever the FSM is not idle

module alu_req_arbiter #(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_fun,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_fun,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_flag,
   output logic             resp_carry,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_fun,
   input  logic [WIDTH-1:0] alu_arith_out,
   input  logic [WIDTH-1:0] alu_logic_out,
   input  logic [WIDTH-1:0] alu_cmp_out,
   input  logic [WIDTH-1:0] alu_shift_out,
   input  logic             alu_arith_flag,
   input  logic             alu_logic_flag,
   input  logic             alu_cmp_flag,
   input  logic             alu_shift_flag,
   input  logic             alu_carry_out,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter must be able to hold ALU_LAT; one spare count for headroom.
   localparam int            CW      = $clog2(ALU_LAT + 2);
   localparam logic [CW-1:0] LAT_CNT = CW'(ALU_LAT);
   localparam logic [3:0]    FUN_NOP = 4'b1000;

   state_t           state;
   state_t           state_nxt;
   logic             last_id;
   logic             cur_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [3:0]       op_fun;
   logic [CW-1:0]    cnt;

   logic             grant_id;
   logic             accept;
   logic             resp_done;
   logic             exec_done;
   logic [WIDTH-1:0] sel_data;
   logic             sel_flag;
   logic             sel_carry;

   // Round-robin: on a tie the requester that was not served last wins;
   // with a single request the requester present wins.
   assign grant_id  = (req0_valid && req1_valid) ? ~last_id : req1_valid;
   assign exec_done = (state == EXEC) && (cnt == LAT_CNT);

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      resp_done   = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_fun     = FUN_NOP;
      case (state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               accept     = 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            alu_a   = op_a;
            alu_b   = op_b;
            alu_fun = op_fun;
            if (exec_done) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            resp0_valid = ~cur_id;
            resp1_valid = cur_id;
            if (cur_id ? resp1_ready : resp0_ready) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Unit select on the latched opcode; carry is only meaningful for arith.
   always_comb begin
      sel_data  = alu_arith_out;
      sel_flag  = alu_arith_flag;
      sel_carry = 1'b0;
      case (op_fun[3:2])
         2'b00: begin
            sel_data  = alu_arith_out;
            sel_flag  = alu_arith_flag;
            sel_carry = alu_carry_out;
         end
         2'b01: begin
            sel_data = alu_logic_out;
            sel_flag = alu_logic_flag;
         end
         2'b10: begin
            sel_data = alu_cmp_out;
            sel_flag = alu_cmp_flag;
         end
         default: begin
            sel_data = alu_shift_out;
            sel_flag = alu_shift_flag;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         last_id    <= 1'b1;
         cur_id     <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_fun     <= FUN_NOP;
         cnt        <= '0;
         resp_data  <= '0;
         resp_flag  <= 1'b0;
         resp_carry <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cur_id <= grant_id;
            op_a   <= grant_id ? req1_a   : req0_a;
            op_b   <= grant_id ? req1_b   : req0_b;
            op_fun <= grant_id ? req1_fun : req0_fun;
            cnt    <= '0;
         end else if (state == EXEC) begin
            cnt <= cnt + 1'b1;
         end
         // Result registers only change on capture, so they stay stable
         // through any amount of response backpressure.
         if (exec_done) begin
            resp_data  <= sel_data;
            resp_flag  <= sel_flag;
            resp_carry <= sel_carry;
         end
         if (resp_done) begin
            last_id <= cur_id;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter

module tb_alu_req_arbiter;

   logic        CLK;
   logic        RST;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_fun, req1_fun;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready, resp1_ready;
   logic [15:0] resp_data;
   logic        resp_flag, resp_carry;
   logic [15:0] alu_a, alu_b;
   logic [3:0]  alu_fun;
   logic [15:0] alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out;
   logic        alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
   logic        alu_carry_out;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   alu_req_arbiter #(.WIDTH(16), .ALU_LAT(1)) dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .resp_flag(resp_flag), .resp_carry(resp_carry),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
      .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out),
      .alu_cmp_out(alu_cmp_out), .alu_shift_out(alu_shift_out),
      .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
      .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag),
      .alu_carry_out(alu_carry_out),
      .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ALU_TOP stand-in: every unit computes from fun[1:0] in parallel and
   // registers its result, so a wrong unit select shows a distinct value.
   //   arith: add, sub, mul, div   flag = result is zero, carry = add carry / sub borrow
   //   logic: and, or, nand, nor   flag = result msb
   //   cmp:   nop, eq, gt, lt      flag = result nonzero
   //   shift: a>>1, a<<1, b>>1, b<<1  flag = result lsb
   logic [16:0] ar_ext;
   logic [15:0] lg_v, cp_v, sh_v;
   always_comb begin
      case (alu_fun[1:0])
         2'b00:   ar_ext = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01:   ar_ext = {1'b0, alu_a} - {1'b0, alu_b};
         2'b10:   ar_ext = {1'b0, alu_a * alu_b};
         default: ar_ext = {1'b0, (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b};
      endcase
      case (alu_fun[1:0])
         2'b00:   lg_v = alu_a & alu_b;
         2'b01:   lg_v = alu_a | alu_b;
         2'b10:   lg_v = ~(alu_a & alu_b);
         default: lg_v = ~(alu_a | alu_b);
      endcase
      case (alu_fun[1:0])
         2'b00:   cp_v = 16'd0;
         2'b01:   cp_v = (alu_a == alu_b) ? 16'd1 : 16'd0;
         2'b10:   cp_v = (alu_a > alu_b)  ? 16'd2 : 16'd0;
         default: cp_v = (alu_a < alu_b)  ? 16'd3 : 16'd0;
      endcase
      case (alu_fun[1:0])
         2'b00:   sh_v = alu_a >> 1;
         2'b01:   sh_v = alu_a << 1;
         2'b10:   sh_v = alu_b >> 1;
         default: sh_v = alu_b << 1;
      endcase
   end

   always_ff @(posedge CLK) begin
      alu_arith_out  <= ar_ext[15:0];
      alu_arith_flag <= (ar_ext[15:0] == 16'd0);
      alu_carry_out  <= (alu_fun[1] == 1'b0) ? ar_ext[16] : 1'b0;
      alu_logic_out  <= lg_v;
      alu_logic_flag <= lg_v[15];
      alu_cmp_out    <= cp_v;
      alu_cmp_flag   <= (cp_v != 16'd0);
      alu_shift_out  <= sh_v;
      alu_shift_flag <= sh_v[0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Full transaction with resp_ready held high, checking the accept, EXEC
   // drive, response latency of 3 cycles, and busy falling afterwards.
   task automatic run_op(input string tag, input logic id,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input logic [15:0] ed, input logic ef, input logic ec);
      if (id) begin
         req1_a = a; req1_b = b; req1_fun = f; req1_valid = 1'b1; resp1_ready = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_fun = f; req0_valid = 1'b1; resp0_ready = 1'b1;
      end
      #1;
      chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 1);
      chk({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 0);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk({tag, "_busy_exec"}, 32'(busy), 1);
      chk({tag, "_alu_drive"}, {alu_fun, 12'h000, alu_a ^ alu_b}, {f, 12'h000, a ^ b});
      cyc();
      chk({tag, "_no_early_resp"}, 32'(id ? resp1_valid : resp0_valid), 0);
      cyc();
      chk({tag, "_resp_valid"}, 32'(id ? resp1_valid : resp0_valid), 1);
      chk({tag, "_other_resp"}, 32'(id ? resp0_valid : resp1_valid), 0);
      chk({tag, "_data"}, 32'(resp_data), 32'(ed));
      chk({tag, "_flag"}, 32'(resp_flag), 32'(ef));
      chk({tag, "_carry"}, 32'(resp_carry), 32'(ec));
      cyc();
      chk({tag, "_busy_done"}, 32'(busy), 0);
      chk({tag, "_resp_drop"}, 32'(id ? resp1_valid : resp0_valid), 0);
   endtask

   task automatic reset_dut();
      RST = 1'b0;
      cyc();
      cyc();
      RST = 1'b1;
      cyc();
   endtask

   initial begin
      RST = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_fun = '0;
      req1_a = '0; req1_b = '0; req1_fun = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;

      // Reset values
      #2;
      chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
      chk("rst_resp_valid", {30'd0, resp0_valid, resp1_valid}, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_resp", {resp_data, 14'd0, resp_flag, resp_carry}, 0);
      chk("rst_alu_fun", 32'(alu_fun), 'h8);
      chk("rst_alu_ab", {alu_a, alu_b}, 0);
      cyc();
      cyc();
      RST = 1'b1;
      cyc();

      // Single add from req0
      run_op("add", 1'b0, 16'd3, 16'd13, 4'b0000, 16'd16, 1'b0, 1'b0);

      // Tie after reset: req0 wins, req1 served next, then req0 wins again
      reset_dut();
      req0_a = 16'd3; req0_b = 16'd13; req0_fun = 4'b0101; req0_valid = 1'b1;
      req1_a = 16'd7; req1_b = 16'd1;  req1_fun = 4'b1010; req1_valid = 1'b1;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      #1;
      chk("tie1_r0_ready", 32'(req0_ready), 1);
      chk("tie1_r1_ready", 32'(req1_ready), 0);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("tie1_r1_blocked", 32'(req1_ready), 0);
      cyc();
      cyc();
      chk("tie1_r0_resp", {30'd0, resp0_valid, resp1_valid}, 'b10);
      chk("tie1_r0_data", 32'(resp_data), 'h000F);
      chk("tie1_r0_flagcarry", {30'd0, resp_flag, resp_carry}, 0);
      cyc();
      chk("tie1_r1_ready_next", {30'd0, req0_ready, req1_ready}, 'b01);
      cyc();
      req1_valid = 1'b0;
      cyc();
      cyc();
      chk("tie1_r1_resp", {30'd0, resp0_valid, resp1_valid}, 'b01);
      chk("tie1_r1_data", 32'(resp_data), 2);
      chk("tie1_r1_flagcarry", {30'd0, resp_flag, resp_carry}, 'b10);
      cyc();
      req0_a = 16'hFFFF; req0_b = 16'd2; req0_fun = 4'b0000; req0_valid = 1'b1;
      req1_a = 16'd3;    req1_b = 16'd1; req1_fun = 4'b1100; req1_valid = 1'b1;
      #1;
      chk("tie2_winner", {30'd0, req0_ready, req1_ready}, 'b10);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc();
      cyc();
      chk("tie2_resp", {30'd0, resp0_valid, resp1_valid}, 'b10);
      chk("tie2_data", 32'(resp_data), 1);
      chk("tie2_flagcarry", {30'd0, resp_flag, resp_carry}, 'b01);
      cyc();

      // Backpressure on req1 for 5 cycles
      req1_a = 16'd3; req1_b = 16'd1; req1_fun = 4'b1100; req1_valid = 1'b1;
      resp1_ready = 1'b0;
      #1;
      chk("bp_accept", 32'(req1_ready), 1);
      cyc();
      req1_valid = 1'b0;
      cyc();
      cyc();
      req0_a = 16'd9; req0_b = 16'd9; req0_fun = 4'b0001; req0_valid = 1'b1;
      resp0_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_hold_valid", {30'd0, resp0_valid, resp1_valid}, 'b01);
         chk("bp_hold_data", {resp_data, 14'd0, resp_flag, resp_carry}, {16'd1, 16'b10});
         chk("bp_hold_r0_ready", 32'(req0_ready), 0);
         chk("bp_hold_busy", 32'(busy), 1);
         cyc();
      end
      req0_valid = 1'b0;
      resp1_ready = 1'b1;
      #1;
      chk("bp_release_valid", 32'(resp1_valid), 1);
      cyc();
      chk("bp_done", {30'd0, busy, resp1_valid}, 0);

      // Carry with zero result through the arith path, via req1
      run_op("add_wrap", 1'b1, 16'hFFFF, 16'd1, 4'b0000, 16'd0, 1'b1, 1'b1);

      // Reset during EXEC drops the operation
      req0_a = 16'd1; req0_b = 16'd1; req0_fun = 4'b0000; req0_valid = 1'b1;
      resp0_ready = 1'b1;
      cyc();
      req0_valid = 1'b0;
      chk("mid_exec_drive", {alu_fun, 12'h000, alu_a}, {4'b0000, 12'h000, 16'd1});
      RST = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_alu", {alu_fun, 12'h000, alu_a ^ alu_b}, {4'b1000, 28'd0});
      chk("mid_rst_alu_a", 32'(alu_a), 0);
      chk("mid_rst_resp", {resp_data, 13'd0, resp_flag, resp_carry, resp0_valid}, 0);
      cyc();
      cyc();
      RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("mid_rst_no_resp", {30'd0, resp0_valid, busy}, 0);
      end

      run_op("nand", 1'b0, 16'd3, 16'd13, 4'b0110, 16'hFFFE, 1'b1, 1'b0);
      run_op("cmp_nop", 1'b0, 16'd3, 16'd13, 4'b1000, 16'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

endmodule
